// File: rtl/obi_arb_pkg.sv
// rtl/obi_arb_pkg.sv - shared IDs and default parameters for the OBI port arbiter
package obi_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_OUTST_DEF = 2;

  typedef enum logic {
    ID_INSTR = 1'b0,
    ID_DATA  = 1'b1
  } arb_id_e;

  function automatic arb_id_e other_id(input arb_id_e id);
    return (id == ID_INSTR) ? ID_DATA : ID_INSTR;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order FIFO of requester IDs for granted-but-unanswered transactions
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             pop_id,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign pop_id = slots[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_id;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      // Simultaneous push and pop leaves the occupancy unchanged
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/obi_port_arbiter.sv
// rtl/obi_port_arbiter.sv - round-robin arbiter merging OBI fetch and load/store ports onto one memory port
module obi_port_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic                instr_gnt,
  output logic                instr_rvalid,
  output logic [DATA_W-1:0]   instr_rdata,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e      state_q, state_d;
  arb_id_e          last_q, lock_id_q, sel;
  logic             sel_req;
  logic             can_issue;
  logic             push, pop, fifo_empty;
  logic             head_id;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      lock_id_q <= ID_INSTR;
      last_q    <= ID_INSTR;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_req && !mem_gnt) lock_id_q <= sel;
      if (push) last_q <= sel;
      if (mem_rvalid && fifo_empty) err <= 1'b1;
    end
  end

  always_comb begin
    sel       = ID_INSTR;
    sel_req   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    push      = 1'b0;
    state_d   = state_q;

    // A pending ungranted command keeps its owner so the memory sees a stable request
    if (state_q == ST_LOCKED)       sel = lock_id_q;
    else if (instr_req && data_req) sel = other_id(last_q);
    else if (data_req)              sel = ID_DATA;

    sel_req = (sel == ID_DATA) ? data_req : instr_req;
    // Issue gating uses only registered occupancy: no rvalid-to-req path
    mem_req = sel_req && can_issue && !rst;

    if (mem_req) begin
      if (sel == ID_DATA) begin
        mem_we    = data_we;
        mem_be    = data_be;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_be    = '1;
        mem_addr  = instr_addr;
      end
    end

    push      = mem_req && mem_gnt;
    instr_gnt = push && (sel == ID_INSTR);
    data_gnt  = push && (sel == ID_DATA);

    if (mem_req && !mem_gnt) state_d = ST_LOCKED;
    else if (push)           state_d = ST_OPEN;
  end

  assign can_issue    = count < CNT_W'(MAX_OUTST);
  assign fifo_empty   = (count == '0);
  assign pop          = mem_rvalid && !fifo_empty && !rst;
  assign instr_rvalid = pop && (head_id == ID_INSTR);
  assign data_rvalid  = pop && (head_id == ID_DATA);
  assign instr_rdata  = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (sel),
    .pop     (pop),
    .pop_id  (head_id),
    .count   (count)
  );

endmodule

// File: tb/tb_obi_port_arbiter.sv
// tb/tb_obi_port_arbiter.sv - scoreboard bench for obi_port_arbiter
module tb_obi_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_gnt, instr_rvalid;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
  } gnt_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obi_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_gnt    (instr_gnt),
    .instr_rvalid (instr_rvalid),
    .instr_rdata  (instr_rdata),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .err          (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic gnt_t exp_instr(input logic [31:0] a);
    gnt_t g;
    g.id = 1'b0; g.addr = a; g.we = 1'b0; g.be = 4'hF;
    return g;
  endfunction

  function automatic gnt_t exp_data(input logic [31:0] a);
    gnt_t g;
    g.id = 1'b1; g.addr = a; g.we = 1'b1; g.be = 4'h3;
    return g;
  endfunction

  function automatic rsp_t exp_rsp(input logic id, input logic [31:0] d);
    rsp_t r;
    r.id = id; r.data = d;
    return r;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a grant or a response
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_gnt || data_gnt) begin
        chk("gnt_onehot", 32'(instr_gnt && data_gnt), 32'h0);
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(data_gnt), 32'hFFFF_FFFF);
        end else begin
          gnt_t g;
          g = gq.pop_front();
          chk("gnt_id", 32'(data_gnt), 32'(g.id));
          chk("gnt_addr", mem_addr, g.addr);
          chk("gnt_we", 32'(mem_we), 32'(g.we));
          chk("gnt_be", 32'(mem_be), 32'(g.be));
        end
      end
      if (instr_rvalid || data_rvalid) begin
        chk("rsp_onehot", 32'(instr_rvalid && data_rvalid), 32'h0);
        if (rq.size() == 0) begin
          chk("rsp_unexpected", 32'(data_rvalid), 32'hFFFF_FFFF);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          chk("rsp_id", 32'(data_rvalid), 32'(r.id));
          chk("rsp_data", data_rvalid ? data_rdata : instr_rdata, r.data);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    instr_addr = 32'h1000; data_addr = 32'h3000; data_we = 1'b1;
    data_be = 4'h3; data_wdata = 32'h55; mem_rdata = 32'h1234;

    // Reset: everything quiet even with all inputs active
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_instr_gnt", 32'(instr_gnt), 0);
    chk("rst_data_gnt", 32'(data_gnt), 0);
    chk("rst_rvalid", 32'({instr_rvalid, data_rvalid}), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata_pass", instr_rdata, 32'h1234);
    next_cycle();
    rst = 1'b0;
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("idle_err", 32'(err), 0);
    chk("idle_mem_req", 32'(mem_req), 0);
    next_cycle();

    // Tie: D, I, D, I with a response each cycle after the first (push/pop at count 1)
    for (int k = 0; k < 4; k++) begin
      instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
      mem_rvalid = (k > 0);
      mem_rdata = 32'hC000_0000 + 32'(k);
      if (k > 0) rq.push_back(exp_rsp(((k - 1) % 2) == 0, mem_rdata));
      gq.push_back((k % 2 == 0) ? exp_data(32'h3000) : exp_instr(32'h1000));
      @(negedge clk);
      chk("tie_mem_req", 32'(mem_req), 1);
      next_cycle();
    end
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hC000_0004;
    rq.push_back(exp_rsp(1'b0, mem_rdata));
    @(negedge clk);
    chk("noreq_mem_req", 32'(mem_req), 0);
    chk("noreq_mem_addr", mem_addr, 0);
    chk("noreq_mem_wdata", mem_wdata, 0);
    next_cycle();
    mem_rvalid = 1'b0;

    // Lock: instr held at 0x2000 while data arrives and would otherwise win
    instr_addr = 32'h2000; instr_req = 1'b1; mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      data_req = (c >= 1);
      @(negedge clk);
      chk("lock_mem_req", 32'(mem_req), 1);
      chk("lock_mem_addr", mem_addr, 32'h2000);
      next_cycle();
    end
    mem_gnt = 1'b1;
    gq.push_back(exp_instr(32'h2000));
    @(negedge clk);
    next_cycle();
    instr_req = 1'b0;
    gq.push_back(exp_data(32'h3000));
    @(negedge clk);
    next_cycle();

    // Full: two outstanding, issue blocked even with rvalid this cycle
    instr_req = 1'b1; data_req = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001;
    rq.push_back(exp_rsp(1'b0, mem_rdata));
    @(negedge clk);
    chk("full_mem_req", 32'(mem_req), 0);
    next_cycle();
    mem_rdata = 32'hBBBB_0002;
    rq.push_back(exp_rsp(1'b1, mem_rdata));
    gq.push_back(exp_instr(32'h2000));
    @(negedge clk);
    chk("resume_mem_req", 32'(mem_req), 1);
    next_cycle();
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
    mem_rdata = 32'hCCCC_0003;
    rq.push_back(exp_rsp(1'b0, mem_rdata));
    @(negedge clk);
    next_cycle();

    // Stray response with nothing outstanding
    mem_rdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("stray_rvalid", 32'({instr_rvalid, data_rvalid}), 0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_err_set", 32'(err), 1);
    next_cycle();
    @(negedge clk);
    chk("stray_err_held", 32'(err), 1);
    next_cycle();

    // Reset pulse clears err and silences outputs
    rst = 1'b1; instr_req = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    chk("pulse_err", 32'(err), 0);
    chk("pulse_mem_req", 32'(mem_req), 0);
    chk("pulse_instr_gnt", 32'(instr_gnt), 0);
    next_cycle();
    rst = 1'b0; instr_req = 1'b0; mem_gnt = 1'b0;

    // Reset mid-operation: first tie goes to data, then the outstanding ID is discarded
    instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1;
    gq.push_back(exp_data(32'h3000));
    @(negedge clk);
    next_cycle();
    rst = 1'b1; instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    next_cycle();
    rst = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid", 32'({instr_rvalid, data_rvalid}), 0);
    next_cycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("midrst_err", 32'(err), 1);
    next_cycle();

    chk("gnt_queue_drained", 32'(gq.size()), 0);
    chk("rsp_queue_drained", 32'(rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_port_arbiter.md
OBI_PORT_ARBITER -- requirements
Module: obi_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_OUTST, default 2, maximum granted-but-unanswered memory transactions (range 1..8).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, named clk and rst as elsewhere in the codebase.
REQ-005 SHALL have these ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- instr_req  in  1  fetch request
- instr_addr  in  ADDR_W  fetch address
- instr_gnt  out  1  fetch accepted
- instr_rvalid  out  1  fetch data valid
- instr_rdata  out  DATA_W  fetch data
- data_req  in  1  load/store request
- data_we  in  1  store when 1
- data_be  in  DATA_W/8  byte enables
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  load/store accepted
- data_rvalid  out  1  load/store response valid
- data_rdata  out  DATA_W  load data
- mem_req  out  1  shared-port request
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  shared-port command
- mem_gnt  in  1  shared-port accept
- mem_rvalid  in  1  shared-port response valid
- mem_rdata  in  DATA_W  shared-port response data
- err  out  1  sticky: response with no outstanding transaction

Function
REQ-006 SHALL perform round-robin selection: on simultaneous instr_req and data_req, the requester not granted last wins; a single requester wins alone.
REQ-007 SHALL drive mem_req = selected req AND outstanding count < MAX_OUTST, combinationally in the same cycle.
REQ-008 SHALL hold the selection (lock) while mem_req=1 and mem_gnt=0, so the mem command stays stable until grant, even if the other requester raises req.
REQ-009 SHALL assert the winner's gnt only when mem_req=1 and mem_gnt=1; the loser's gnt SHALL be 0.
REQ-010 SHALL drive mem_we=0 and mem_be=all-ones for instr transactions, and pass data_we/data_be/data_wdata through for data transactions.
REQ-011 SHALL, when no requester is active, drive mem_req=0 and mem_addr/mem_wdata=0.
REQ-012 SHALL push the winner ID into an in-order ID FIFO of depth MAX_OUTST on every mem_req AND mem_gnt cycle.
REQ-013 SHALL, on mem_rvalid with the FIFO non-empty, pop the head ID and assert exactly one of instr_rvalid/data_rvalid in that same cycle (zero-latency routing).
REQ-014 SHALL broadcast mem_rdata onto instr_rdata and data_rdata unconditionally.
REQ-015 SHALL keep the outstanding count unchanged on a simultaneous push and pop.
REQ-016 SHALL block issue when count = MAX_OUTST, even if mem_rvalid arrives in that cycle, so there is no rvalid-to-req combinational path.
REQ-017 SHALL, on mem_rvalid with the FIFO empty, assert no rvalid, set err and hold it until reset.
REQ-018 SHALL update the last-granted pointer only on a granted cycle.

Reset
REQ-019 SHALL, while rst=1, empty the FIFO, clear count, lock and err, and set the last-granted pointer to instr, so data wins the first tie.
REQ-020 SHALL drive all outputs to 0 during reset, except combinational rdata passthrough.
REQ-021 SHALL, on reset mid-operation, discard outstanding IDs; a later stray mem_rvalid sets err per REQ-017.

Structure
REQ-022 SHALL place ID_INSTR=0, ID_DATA=1 and default parameter values in shared package obi_arb_pkg.
REQ-023 SHALL implement the ID FIFO as sub-module arb_id_fifo (depth MAX_OUTST, 1-bit entries, count output, wrap-around pointers).

Verification
REQ-024 Tie: instr_req=data_req=1 after reset, mem_gnt=1 -> data_gnt first cycle, instr_gnt second, then alternating.
REQ-025 Lock: instr_req=1 at 0x2000, mem_gnt=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays 0x2000 until grant, and instr is granted first.
REQ-026 Full: MAX_OUTST=2, two grants with no rvalid -> mem_req=0 in the third cycle despite req; first mem_rvalid -> issue resumes the next cycle.
REQ-027 Ordering: grant instr then data, then two mem_rvalid returning 0xAAAA_0001 and 0xBBBB_0002 -> instr_rvalid with the first word, then data_rvalid with the second.
REQ-028 Stray response: mem_rvalid=1 with empty FIFO -> no rvalid, err=1 and held; rst pulse -> err=0.
REQ-029 Push/pop: grant and mem_rvalid in the same cycle at count=1 -> count stays 1 and routing is correct.
